// File: rtl/sata_oobctrl_if.sv
// PHY-side bundle of the OOB sequencer: burst generator handshake, COM/ALIGN detectors, status.
// o_retries exists only when SATA_OOB_RETRYLIMIT_EN is defined.
interface sata_oobctrl_if;
    logic       i_cominit_det;
    logic       i_comwake_det;
    logic       i_burst_done;
    logic       i_rx_align;
    logic       o_burst_req;
    logic       o_burst_type;
    logic       o_tx_elecidle;
    logic       o_tx_align;
    logic       o_link_up;
    logic [3:0] o_state;
`ifdef SATA_OOB_RETRYLIMIT_EN
    logic [3:0] o_retries;

    modport master (
        input  i_cominit_det, i_comwake_det, i_burst_done, i_rx_align,
        output o_burst_req, o_burst_type, o_tx_elecidle, o_tx_align, o_link_up, o_state, o_retries
    );
    modport slave (
        output i_cominit_det, i_comwake_det, i_burst_done, i_rx_align,
        input  o_burst_req, o_burst_type, o_tx_elecidle, o_tx_align, o_link_up, o_state, o_retries
    );
`else
    modport master (
        input  i_cominit_det, i_comwake_det, i_burst_done, i_rx_align,
        output o_burst_req, o_burst_type, o_tx_elecidle, o_tx_align, o_link_up, o_state
    );
    modport slave (
        output i_cominit_det, i_comwake_det, i_burst_done, i_rx_align,
        input  o_burst_req, o_burst_type, o_tx_elecidle, o_tx_align, o_link_up, o_state
    );
`endif
endinterface

// File: rtl/sata_oobctrl.sv
// Host-side SATA OOB sequencer: COMRESET, COMINIT, COMWAKE, ALIGN, then link up; retries on timeout.
// Optional SATA_OOB_RETRYLIMIT_EN adds o_retries and a terminal S_FAILED state.
//
// state       | meaning
// S_RESET     | request COMRESET burst
// S_WAIT_INIT | wait for device COMINIT
// S_INIT_END  | wait for COMINIT to end
// S_WAKE      | request COMWAKE burst
// S_WAIT_WAKE | wait for device COMWAKE
// S_WAKE_END  | wait for COMWAKE to end
// S_ALIGN     | send ALIGN, wait for ALIGN
// S_LINKUP    | link up
// S_RETRY     | back-off before the next attempt
// S_FAILED    | attempt limit reached (retry-limit build only)
module sata_oobctrl #(
    parameter int RETRY_CYCLES  = 400000,
    parameter int INIT_TIMEOUT  = 200000,
    parameter int WAKE_TIMEOUT  = 200000,
    parameter int ALIGN_TIMEOUT = 65536,
    parameter int MAX_RETRIES   = 15
) (
    input  logic           i_txclk,
    input  logic           i_reset,
    sata_oobctrl_if.master oob
);
    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_WAIT_INIT = 4'd1;
    localparam logic [3:0] S_INIT_END  = 4'd2;
    localparam logic [3:0] S_WAKE      = 4'd3;
    localparam logic [3:0] S_WAIT_WAKE = 4'd4;
    localparam logic [3:0] S_WAKE_END  = 4'd5;
    localparam logic [3:0] S_ALIGN     = 4'd6;
    localparam logic [3:0] S_LINKUP    = 4'd7;
    localparam logic [3:0] S_RETRY     = 4'd8;
`ifdef SATA_OOB_RETRYLIMIT_EN
    localparam logic [3:0] S_FAILED    = 4'd9;
`endif

    localparam int MAX_IW  = (INIT_TIMEOUT > WAKE_TIMEOUT) ? INIT_TIMEOUT : WAKE_TIMEOUT;
    localparam int MAX_AR  = (ALIGN_TIMEOUT > RETRY_CYCLES) ? ALIGN_TIMEOUT : RETRY_CYCLES;
    localparam int TMR_MAX = (MAX_IW > MAX_AR) ? MAX_IW : MAX_AR;
    localparam int TW      = $clog2(TMR_MAX) + 1;

    if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_max_retries_range
        $error("MAX_RETRIES must fit the 4-bit retry counter");
    end

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic [3:0]    give_up;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_load;
    logic          timeout;

    assign timeout = (tmr == '0);

`ifdef SATA_OOB_RETRYLIMIT_EN
    logic [3:0] retries;
    assign give_up       = (retries == 4'(MAX_RETRIES)) ? S_FAILED : S_RETRY;
    assign oob.o_retries = retries;
`else
    assign give_up = S_RETRY;
`endif

    // Detection wins over a coincident timeout, except COMINIT during the COMWAKE wait restarts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:     if (oob.i_burst_done) state_nxt = S_WAIT_INIT;
            S_WAIT_INIT: if (oob.i_cominit_det) state_nxt = S_INIT_END;
                         else if (timeout) state_nxt = give_up;
            S_INIT_END:  if (!oob.i_cominit_det) state_nxt = S_WAKE;
            S_WAKE:      if (oob.i_burst_done) state_nxt = S_WAIT_WAKE;
            S_WAIT_WAKE: if (oob.i_comwake_det) state_nxt = S_WAKE_END;
                         else if (timeout) state_nxt = oob.i_cominit_det ? S_RESET : give_up;
            S_WAKE_END:  if (!oob.i_comwake_det) state_nxt = S_ALIGN;
            S_ALIGN:     if (oob.i_rx_align) state_nxt = S_LINKUP;
                         else if (timeout) state_nxt = give_up;
            S_LINKUP:    if (oob.i_cominit_det) state_nxt = S_RESET;
            S_RETRY:     if (timeout) state_nxt = S_RESET;
`ifdef SATA_OOB_RETRYLIMIT_EN
            S_FAILED:    state_nxt = S_FAILED;
`endif
            default:     state_nxt = S_RESET;
        endcase
    end

    // Loading N-1 on entry makes the timeout edge land exactly N cycles after entry.
    always_comb begin
        tmr_load = '0;
        case (state_nxt)
            S_WAIT_INIT: tmr_load = TW'(INIT_TIMEOUT - 1);
            S_WAIT_WAKE: tmr_load = TW'(WAKE_TIMEOUT - 1);
            S_ALIGN:     tmr_load = TW'(ALIGN_TIMEOUT - 1);
            S_RETRY:     tmr_load = TW'(RETRY_CYCLES - 1);
            default:     tmr_load = '0;
        endcase
    end

    always_ff @(posedge i_txclk) begin
        if (i_reset) begin
            state             <= S_RESET;
            tmr               <= '0;
            oob.o_burst_req   <= 1'b0;
            oob.o_burst_type  <= 1'b0;
            oob.o_tx_elecidle <= 1'b1;
            oob.o_tx_align    <= 1'b0;
            oob.o_link_up     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tmr <= tmr_load;
            end else if (!timeout) begin
                tmr <= tmr - 1'b1;
            end
            oob.o_burst_req   <= (state_nxt == S_RESET) || (state_nxt == S_WAKE);
            oob.o_burst_type  <= (state_nxt == S_WAKE);
            oob.o_tx_elecidle <= !((state_nxt == S_ALIGN) || (state_nxt == S_LINKUP));
            oob.o_tx_align    <= (state_nxt == S_ALIGN);
            oob.o_link_up     <= (state_nxt == S_LINKUP);
        end
    end

`ifdef SATA_OOB_RETRYLIMIT_EN
    always_ff @(posedge i_txclk) begin
        if (i_reset) begin
            retries <= 4'd0;
        end else if (state_nxt == S_RETRY && state != S_RETRY && retries != 4'hF) begin
            retries <= retries + 4'd1;
        end
    end
`endif

    assign oob.o_state = state;
endmodule

// File: doc/sata_oobctrl.md
# sata_oobctrl

Host-side out-of-band (OOB) sequencer for the SATA PHY. It runs COMRESET, COMINIT, COMWAKE and ALIGN in order, so the link comes up against a device such as the bench COM-handshake model. It commands an external burst generator, watches an external COM detector and an ALIGN detector, and raises `o_link_up` once the handshake completes. If any phase times out, it retries the whole sequence from COMRESET.

## Interface
Parameters:
- `RETRY_CYCLES`, 400000: idle cycles between a failed attempt and the next COMRESET.
- `INIT_TIMEOUT`, 200000: cycles to wait for COMINIT after COMRESET completes.
- `WAKE_TIMEOUT`, 200000: cycles to wait for COMWAKE after the host's COMWAKE completes.
- `ALIGN_TIMEOUT`, 65536: cycles to wait for ALIGN while sending ALIGN.
- `MAX_RETRIES`, 15: attempt limit. Used only with `SATA_OOB_RETRYLIMIT_EN`.

Ports:
- `i_txclk`  in  1  clock.
- `i_reset`  in  1  reset, synchronous, active-high; clock `i_txclk`.
- `i_cominit_det`  in  1  COMINIT/COMRESET detected (level, already synchronised to `i_txclk`).
- `i_comwake_det`  in  1  COMWAKE detected (level, synchronised).
- `i_burst_done`  in  1  one-cycle pulse: the requested burst sequence has finished.
- `i_rx_align`  in  1  ALIGN primitive received this cycle.
- `o_burst_req`  out  1  request a burst sequence from the generator.
- `o_burst_type`  out  1  0 = COMRESET, 1 = COMWAKE.
- `o_tx_elecidle`  out  1  transmitter held in electrical idle.
- `o_tx_align`  out  1  transmit ALIGN primitives.
- `o_link_up`  out  1  OOB complete.
- `o_state`  out  4  current state encoding, for debug.
- `o_retries`  out  4  attempts so far, saturating. Present only with `SATA_OOB_RETRYLIMIT_EN`.

## Operation
States and encodings:
- `S_RESET` 0: assert `o_burst_req` with `o_burst_type`=0.
  - On `i_burst_done` → `S_WAIT_INIT`.
- `S_WAIT_INIT` 1: wait for COMINIT.
  - `i_cominit_det` → `S_INIT_END`.
  - Timer reaches `INIT_TIMEOUT` → `S_RETRY`.
- `S_INIT_END` 2: wait for `i_cominit_det` to fall.
  - On the fall → `S_WAKE`.
- `S_WAKE` 3: assert `o_burst_req` with `o_burst_type`=1.
  - On `i_burst_done` → `S_WAIT_WAKE`.
- `S_WAIT_WAKE` 4: wait for the device's COMWAKE.
  - `i_comwake_det` → `S_WAKE_END`.
  - Timeout `WAKE_TIMEOUT` → `S_RETRY`.
- `S_WAKE_END` 5: wait for `i_comwake_det` to fall.
  - On the fall → `S_ALIGN`.
- `S_ALIGN` 6: `o_tx_align`=1, `o_tx_elecidle`=0.
  - `i_rx_align` → `S_LINKUP`.
  - Timeout `ALIGN_TIMEOUT` → `S_RETRY`.
- `S_LINKUP` 7: `o_link_up`=1, `o_tx_align`=0.
  - `i_cominit_det` (device-initiated reset) → `S_RESET`.
- `S_RETRY` 8: idle for `RETRY_CYCLES`, then → `S_RESET`.
- `S_FAILED` 9: reachable only with `SATA_OOB_RETRYLIMIT_EN`. Absorbing until `i_reset`.

Output rules:
- `o_tx_elecidle`=1 in every state except `S_ALIGN` and `S_LINKUP`.
- Burst handshake: `o_burst_req` and `o_burst_type` are held stable from state entry until the cycle `i_burst_done` is sampled.
  - `o_burst_req` drops the cycle after `i_burst_done` is sampled.
  - `i_burst_done` outside `S_RESET`/`S_WAKE` is ignored.
- Timers: a single down-counter, width `$clog2` of the largest timeout parameter plus 1.
  - Loaded on every state entry and decremented each cycle.
  - Timeout fires when the counter reads 0, so the timeout edge is exactly N cycles after entry.
- Simultaneous events: detection takes priority over timeout on the same cycle.
  - Exception: in `S_WAIT_WAKE`, a simultaneous `i_cominit_det` restarts at `S_RESET`.
- Unused encodings go to `S_RESET`.

## Timing
Reset values (registered outputs, `i_reset` high):
- `o_burst_req`=0, `o_burst_type`=0, `o_tx_elecidle`=1, `o_tx_align`=0, `o_link_up`=0, `o_state`=0, `o_retries`=0.
- First cycle after reset release: state `S_RESET`, `o_burst_req`=1.

Latency:
- Every transition takes effect one cycle after the qualifying input is sampled.
- Outputs are registered and reflect the new state on that same edge.
- `o_link_up` rises 1 cycle after `i_rx_align` is sampled in `S_ALIGN`.
- `o_link_up` falls 1 cycle after `i_cominit_det` is sampled in `S_LINKUP`.
- `i_reset` mid-sequence aborts immediately to reset values, including any outstanding burst request.

## Configuration
Macro `SATA_OOB_RETRYLIMIT_EN`.
- Defined:
  - `o_retries` exists and increments (saturating at 15) on each entry to `S_RETRY`.
  - On entry to `S_RETRY` with `o_retries`==`MAX_RETRIES`, the block goes to `S_FAILED` instead: electrical idle held, no further requests.
- Undefined:
  - Port `o_retries` is absent.
  - The block retries forever; `S_FAILED` is never reached.

## Test plan
- Clean bring-up:
  - Stimulus: device model answers COMINIT 100 cycles after `i_burst_done`, COMWAKE 50 cycles after the second `i_burst_done`, ALIGN 20 cycles later.
  - Required: `o_state` walks 0→1→2→3→4→5→6→7, `o_link_up`=1, `o_tx_elecidle`=0.
- COMINIT timeout:
  - Stimulus: no COMINIT.
  - Required: `S_RETRY` exactly `INIT_TIMEOUT` cycles after entering `S_WAIT_INIT`, then `S_RESET` after `RETRY_CYCLES`, with `o_burst_req`=1 again.
- Burst handshake:
  - Stimulus: hold `i_burst_done` low for 500 cycles.
  - Required: `o_burst_req`/`o_burst_type` stable for the whole wait; `o_burst_req` deasserts the cycle after the done pulse.
- Device reset while up:
  - Stimulus: `i_cominit_det` pulse in `S_LINKUP`.
  - Required: `o_link_up`=0 next cycle, state 0, COMRESET reissued.
- Reset mid-`S_ALIGN`:
  - Stimulus: assert `i_reset` during `S_ALIGN`.
  - Required: all outputs at reset values the next cycle; `o_tx_align`=0.
- Retry limit (macro defined, `MAX_RETRIES`=2, no device responses):
  - Required: `o_retries` counts 1, 2, then `S_FAILED` (state 9) with no further `o_burst_req`.
